pe_instruction: RTL and testbench
=================================

Name: pe_instruction

Overview:
- Floating-point multiply-accumulate processing element wrapped as a Nios II multi-cycle custom instruction.
- The CPU streams IEEE-754 single-precision kernel weights and input activations through `dataa`, selecting the operation with `n`.
- The block holds one kernel operand, one input operand and one accumulator.
- It forms the MAC core of the convolution engine; the accumulated output is read back via `result`.

Parameters:
- DATA_W, 32, operand/result width (IEEE-754 single precision; fixed).
- OP_W, 3, width of opcode port `n`.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- clk_en  input  1  clock enable; when low, all registers including done/result hold.
- start  input  1  command strobe, sampled at a rising edge with clk_en=1.
- n  input  3  opcode.
- dataa  input  32  operand (FP32 bit pattern).
- result  output  32  registered command result.
- done  output  1  registered completion flag.

Behaviour:
- Reset (reset=0 at a rising edge, regardless of clk_en): result=0, done=0, kernel_reg=0, input_reg=0, acc=0.
- Command acceptance: at a rising edge with reset=1, clk_en=1 and start=1, execute opcode n; done=1 and result are valid after that edge (latency 1 cycle).
- At an edge with clk_en=1 and start=0: done=0, result holds, no state change.
- start may stay high on consecutive cycles; each edge is an independent command, back-to-back throughput is 1 per cycle.
- Opcodes:
  - n=0 CLEAR: kernel_reg, input_reg and acc set to 0; result=0.
  - n=1 LOAD_KERNEL: kernel_reg<=dataa; result=dataa.
  - n=2 LOAD_INPUT: input_reg<=dataa; result=dataa.
  - n=3 MAC: acc<=acc + kernel_reg*input_reg, using register values before this edge; result=new acc; dataa ignored.
  - n=4 READ_CLEAR: result=acc (pre-clear value); acc<=0; operand registers unchanged.
  - n=5..7: no-op; result=acc; done=1.
- FP arithmetic (combinational multiplier followed by adder, single cycle):
  - Normalized numbers only; denormal inputs are flushed to signed zero.
  - Rounding is truncation (round toward zero).
  - Exponent overflow gives ±Inf (exp 0xFF, mantissa 0).
  - Underflow gives +0.
  - An exact-zero sum gives +0.
  - NaN/Inf inputs propagate as Inf with the product/sum sign; no NaN generation is required.
  - Exact small-integer products and sums must be bit-exact.
- Simultaneous events:
  - reset=0 overrides start and clk_en.
  - clk_en=0 overrides start: the command is dropped, and done/result keep their previous values.
- Reset mid-sequence discards the operand registers and the accumulator.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release with start=0 -> result=0x00000000, done=0.
- Single MAC: n=1 dataa=0x40800000 (4); n=2 0x41A00000 (20); n=3 -> done=1 each cycle, result echoes on loads, then result=0x42A00000 (80).
- Block sequence with start held high: n/dataa = 1/4, 2/20, 3/20, 1/5, 2/1, 3/7, 1/5, 2/1, 3/1, 2/5, 3/5, 2/7, 2/70 -> n=3 results 80, 85 (0x42AA0000), 90, 115 (0x42E60000); acc=115.
- Four repeated blocks, then n=4 with start=1 -> result=0x43E60000 (460); a following n=3 with operands 70 and 5 gives 350 (0x43AF0000), confirming acc was cleared.
- clk_en gating:
  - Issue n=4 with start=0, clk_en=0 for 5 cycles: done and result frozen, acc unchanged.
  - Then clk_en=1, start=1, n=4: result returns the full acc.
- CLEAR and edge cases:
  - n=0 -> result 0; a following n=3 gives 0x00000000.
  - Kernel 0x7F000000 × input 0x40800000 with n=3 -> 0x7F800000 (overflow to +Inf).

Source files
------------

// File: rtl/pe_instruction.sv
// pe_instruction: FP32 multiply-accumulate processing element packaged as a
// Nios II multi-cycle custom instruction. It holds one kernel operand, one
// input operand and one accumulator, and answers each accepted command with
// a registered result and a one-cycle done pulse.
module pe_instruction #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [OP_W-1:0]   n,
    input  logic [DATA_W-1:0] dataa,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    typedef enum logic [OP_W-1:0] {
        OP_CLEAR       = 3'd0,
        OP_LOAD_KERNEL = 3'd1,
        OP_LOAD_INPUT  = 3'd2,
        OP_MAC         = 3'd3,
        OP_READ_CLEAR  = 3'd4
    } op_e;

    // FP32 multiply: denormals flush to signed zero, truncating rounding,
    // overflow saturates to signed Inf, underflow gives +0.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [10:0] e;
        logic [22:0]        f;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'b0};
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'b0};
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
        if (p[47]) begin
            e = e + 11'sd1;
            f = p[46:24];
        end else begin
            f = p[45:23];
        end
        if (e >= 11'sd255) return {s, 8'hFF, 23'b0};
        if (e <= 11'sd0) return 32'b0;
        return {s, e[7:0], f};
    endfunction

    // FP32 add: three extra bits (guard/round/sticky) keep the truncated
    // result exact for effective subtraction; exact-zero sums give +0.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x;
        logic [31:0]        y;
        logic [7:0]         d;
        logic [26:0]        mx;
        logic [26:0]        my;
        logic [26:0]        mask;
        logic               sticky;
        logic [27:0]        s;
        logic [4:0]         lz;
        logic signed [10:0] e;
        if (a[30:23] == 8'hFF) return {a[31], 8'hFF, 23'b0};
        if (b[30:23] == 8'hFF) return {b[31], 8'hFF, 23'b0};
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return 32'b0;
        if (a[30:23] == 8'h00) return b;
        if (b[30:23] == 8'h00) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d      = x[30:23] - y[30:23];
        mx     = {1'b1, x[22:0], 3'b0};
        my     = {1'b1, y[22:0], 3'b0};
        mask   = '0;
        sticky = 1'b0;
        // Smaller operand is aligned; every bit shifted out folds into bit 0.
        if (d >= 8'd27) begin
            my = 27'd1;
        end else begin
            mask   = (27'd1 << d) - 27'd1;
            sticky = |(my & mask);
            my     = (my >> d) | {26'b0, sticky};
        end
        e = $signed({3'b0, x[30:23]});
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = {1'b0, s[27:1]} | {27'b0, s[0]};
                e = e + 11'sd1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            if (s == 28'd0) return 32'b0;
            lz = '0;
            for (int unsigned i = 0; i < 27; i++) begin
                if (s[i]) lz = 5'(26 - i);
            end
            s = s << lz;
            e = e - $signed({6'b0, lz});
        end
        if (e >= 11'sd255) return {x[31], 8'hFF, 23'b0};
        if (e <= 11'sd0) return 32'b0;
        return {x[31], e[7:0], s[25:3]};
    endfunction

    logic [DATA_W-1:0] kernel_q, kernel_d;
    logic [DATA_W-1:0] input_q, input_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mac_sum;

    assign mac_sum = fp_add(acc_q, fp_mul(kernel_q, input_q));

    // Decode the command accepted at this edge into next-state values.
    always_comb begin
        kernel_d = kernel_q;
        input_d  = input_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = done_q;
        if (clk_en) begin
            done_d = start;
            if (start) begin
                case (n)
                    OP_CLEAR: begin
                        kernel_d = '0;
                        input_d  = '0;
                        acc_d    = '0;
                        result_d = '0;
                    end
                    OP_LOAD_KERNEL: begin
                        kernel_d = dataa;
                        result_d = dataa;
                    end
                    OP_LOAD_INPUT: begin
                        input_d  = dataa;
                        result_d = dataa;
                    end
                    OP_MAC: begin
                        acc_d    = mac_sum;
                        result_d = mac_sum;
                    end
                    OP_READ_CLEAR: begin
                        acc_d    = '0;
                        result_d = acc_q;
                    end
                    default: result_d = acc_q;
                endcase
            end
        end
    end

    // State registers; reset wins over clk_en.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kernel_q <= '0;
            input_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            kernel_q <= kernel_d;
            input_q  <= input_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_pe_instruction.sv
// tb_pe_instruction: scoreboard bench for pe_instruction. The driver models
// operands as integers, encodes expected results as FP32 and queues them;
// a monitor pops and compares after each accepting edge.
module tb_pe_instruction;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [2:0]  n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;

    always #5 clk = ~clk;

    pe_instruction #(.DATA_W(32), .OP_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] res;
    } sb_t;

    sb_t         sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int          km, im, am;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Exact FP32 encoding of an integer with magnitude below 2^24.
    function automatic logic [31:0] int2fp(input int v);
        logic [31:0] m;
        int          p;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        m = m << (23 - p);
        return {v < 0, 8'(127 + p), m[22:0]};
    endfunction

    // Monitor: classify each edge from the inputs seen there, then compare.
    logic        m_r, m_e, m_s;
    logic [31:0] hold_res = '0;
    logic        hold_done = 1'b0;
    sb_t         m_x;
    always @(posedge clk) begin
        m_r = reset;
        m_e = clk_en;
        m_s = start;
        #1;
        if (!m_r) begin
            check("reset_result", result, 32'h0);
            check("reset_done", {31'b0, done}, 32'h0);
            hold_res  = '0;
            hold_done = 1'b0;
        end else if (!m_e) begin
            check("gated_result", result, hold_res);
            check("gated_done", {31'b0, done}, {31'b0, hold_done});
        end else if (!m_s) begin
            check("idle_result", result, hold_res);
            check("idle_done", {31'b0, done}, 32'h0);
            hold_done = 1'b0;
        end else if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            m_x = sb_q.pop_front();
            check($sformatf("op%0d_result", m_x.op), result, m_x.res);
            check($sformatf("op%0d_done", m_x.op), {31'b0, done}, 32'h1);
            hold_res  = m_x.res;
            hold_done = 1'b1;
        end
    end

    task automatic push(input logic [2:0] op, input logic [31:0] res);
        sb_t e;
        e.op  = op;
        e.res = res;
        sb_q.push_back(e);
    endtask

    // Accepted command with an integer operand, tracked by the model.
    task automatic cmd(input logic [2:0] op, input int v);
        @(negedge clk);
        clk_en = 1'b1;
        start  = 1'b1;
        n      = op;
        dataa  = int2fp(v);
        case (op)
            3'd0: begin km = 0; im = 0; am = 0; push(op, 32'h0); end
            3'd1: begin km = v; push(op, int2fp(v)); end
            3'd2: begin im = v; push(op, int2fp(v)); end
            3'd3: begin am = am + km * im; push(op, int2fp(am)); end
            3'd4: begin push(op, int2fp(am)); am = 0; end
            default: push(op, int2fp(am));
        endcase
    endtask

    // Accepted command with raw bits and an explicit expected result.
    task automatic raw(input logic [2:0] op, input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        clk_en = 1'b1;
        start  = 1'b1;
        n      = op;
        dataa  = d;
        push(op, exp);
    endtask

    // Edges where no command is accepted (clk_en=0 or start=0).
    task automatic idle(input logic en, input logic st, input logic [2:0] op, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            clk_en = en;
            start  = st;
            n      = op;
            dataa  = 32'h41200000;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b1;
        n      = 3'd3;
        repeat (cycles) @(negedge clk);
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        km = 0; im = 0; am = 0;
    endtask

    task automatic block();
        cmd(1, 4);  cmd(2, 20); cmd(3, 0);
        cmd(1, 5);  cmd(2, 1);  cmd(3, 0);
        cmd(1, 5);  cmd(2, 1);  cmd(3, 0);
        cmd(2, 5);  cmd(3, 0);
        cmd(2, 7);  cmd(2, 70);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        clk_en = 1'b1;
        start  = 1'b0;
        n      = '0;
        dataa  = '0;
        km = 0; im = 0; am = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(1, 0, 0, 1);

        // Single MAC: 4 * 20 = 80
        cmd(1, 4); cmd(2, 20); cmd(3, 0);

        // Four blocks of 115 each, read-clear 460, then 5*70 from zero
        cmd(0, 0);
        repeat (4) block();
        cmd(4, 0);
        cmd(3, 0);

        // clk_en gating holds everything, including dropped commands
        idle(0, 0, 4, 5);
        idle(0, 1, 4, 3);
        idle(1, 0, 4, 1);
        cmd(4, 0);

        // Negative product, no-op opcodes, exact-zero sum
        cmd(1, -3); cmd(2, 7); cmd(3, 0);
        cmd(5, 0); cmd(6, 0); cmd(7, 0);
        cmd(1, 3); cmd(3, 0);
        cmd(3, 0);

        // CLEAR then MAC on zeroed operands
        cmd(1, 9); cmd(2, 9); cmd(3, 0);
        cmd(0, 0); cmd(3, 0);

        // Overflow to +Inf and -Inf
        raw(1, 32'h7F000000, 32'h7F000000);
        raw(2, 32'h40800000, 32'h40800000);
        raw(3, 32'h0, 32'h7F800000);
        cmd(0, 0);
        raw(1, 32'hFF000000, 32'hFF000000);
        raw(2, 32'h40800000, 32'h40800000);
        raw(3, 32'h0, 32'hFF800000);
        cmd(0, 0);

        // Denormal flushed to -0; -0 + 0 is +0
        raw(1, 32'h80400000, 32'h80400000);
        raw(2, 32'h40800000, 32'h40800000);
        raw(3, 32'h0, 32'h00000000);
        cmd(0, 0);

        // Underflow: min normal * 0.5 gives +0
        raw(1, 32'h00800000, 32'h00800000);
        raw(2, 32'h3F000000, 32'h3F000000);
        raw(3, 32'h0, 32'h00000000);
        cmd(0, 0);

        // Reset mid-sequence discards operands and accumulator
        cmd(1, 3); cmd(2, 9); cmd(3, 0);
        do_reset(2);
        cmd(3, 0);
        cmd(4, 0);

        idle(1, 0, 0, 2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
